// File: rtl/core_ctrl.sv
// core_ctrl: per-cycle instruction sequencer for one systolic-core tile pass
// (weight load, kernel load, execute, psum drain).
module core_ctrl #(
  parameter int unsigned row     = 8,
  parameter int unsigned col     = 8,
  parameter int unsigned addr_bw = 11
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [addr_bw-1:0]     w_base,
  input  logic [addr_bw-1:0]     x_base,
  input  logic [addr_bw-1:0]     p_base,
  input  logic [addr_bw-1:0]     n_act,
  input  logic                   ofifo_valid,
  output logic [3*addr_bw+13:0]  inst,
  output logic                   busy,
  output logic                   done
);

  localparam int unsigned cnt_w = addr_bw + 1;

  typedef struct packed {
    logic               cen_x;
    logic               wen_x;
    logic [addr_bw-1:0] a_x;
    logic               acc;
    logic               cen_p;
    logic               wen_p;
    logic [addr_bw-1:0] a_p;
    logic               cen_w;
    logic               wen_w;
    logic [addr_bw-1:0] a_w;
    logic               ofifo_rd;
    logic               l0_wr_w;
    logic               ififo_rd;
    logic               l0_rd;
    logic               l0_wr_x;
    logic               execute;
    logic               load;
  } inst_t;

  typedef enum logic [2:0] {IDLE, WLOAD, KLOAD, EXEC, DRAIN, DONE_ST} state_t;

  state_t             state;
  logic [cnt_w-1:0]   k_q;
  logic [addr_bw-1:0] j_q;
  logic [addr_bw-1:0] w_q, x_q, p_q, n_q;
  inst_t              inst_q;
  inst_t              inst_d;

  // All SRAMs deselected, no writes, every control bit low.
  function automatic inst_t idle_word();
    inst_t v;
    v       = '0;
    v.cen_x = 1'b1;
    v.wen_x = 1'b1;
    v.cen_p = 1'b1;
    v.wen_p = 1'b1;
    v.cen_w = 1'b1;
    v.wen_w = 1'b1;
    return v;
  endfunction

  // Decode the instruction word for the current state and counters.
  always_comb begin
    inst_d = idle_word();
    unique case (state)
      WLOAD: begin
        if (k_q < cnt_w'(row)) begin
          inst_d.cen_w = 1'b0;
          inst_d.a_w   = w_q + k_q[addr_bw-1:0];
        end
        // L0 write trails the weight read by the SRAM latency
        if (k_q != '0) inst_d.l0_wr_w = 1'b1;
      end
      KLOAD: begin
        inst_d.l0_rd = 1'b1;
        inst_d.load  = 1'b1;
      end
      EXEC: begin
        if (k_q < {1'b0, n_q}) begin
          inst_d.cen_x = 1'b0;
          inst_d.a_x   = x_q + k_q[addr_bw-1:0];
        end
        if (k_q != '0) begin
          inst_d.l0_wr_x = 1'b1;
          inst_d.l0_rd   = 1'b1;
          inst_d.execute = 1'b1;
        end
      end
      DRAIN: begin
        if (ofifo_valid) begin
          inst_d.ofifo_rd = 1'b1;
          inst_d.cen_p    = 1'b0;
          inst_d.wen_p    = 1'b0;
          inst_d.a_p      = p_q + j_q;
        end
      end
      default: ;
    endcase
  end

  // Pass FSM: state, counters, latched parameters and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      k_q    <= '0;
      j_q    <= '0;
      w_q    <= '0;
      x_q    <= '0;
      p_q    <= '0;
      n_q    <= '0;
      inst_q <= idle_word();
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      inst_q <= inst_d;
      done   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            w_q   <= w_base;
            x_q   <= x_base;
            p_q   <= p_base;
            n_q   <= n_act;
            k_q   <= '0;
            busy  <= 1'b1;
            state <= WLOAD;
          end
        end
        WLOAD: begin
          if (k_q == cnt_w'(row)) begin
            k_q   <= '0;
            state <= KLOAD;
          end else begin
            k_q <= k_q + cnt_w'(1);
          end
        end
        KLOAD: begin
          if (k_q == cnt_w'(row + col - 1)) begin
            k_q   <= '0;
            state <= (n_q == '0) ? DONE_ST : EXEC;
          end else begin
            k_q <= k_q + cnt_w'(1);
          end
        end
        EXEC: begin
          if (k_q == {1'b0, n_q}) begin
            k_q   <= '0;
            j_q   <= '0;
            state <= DRAIN;
          end else begin
            k_q <= k_q + cnt_w'(1);
          end
        end
        DRAIN: begin
          if (ofifo_valid) begin
            j_q <= j_q + addr_bw'(1);
            if (j_q + addr_bw'(1) == n_q) state <= DONE_ST;
          end
        end
        DONE_ST: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign inst = inst_q;

endmodule

// File: tb/tb_core_ctrl.sv
// tb_core_ctrl: table of tile passes checked cycle by cycle against an
// expected-word queue built from the pass phase lengths and field layout.
module tb_core_ctrl;

  localparam int unsigned AW = 11;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] w_base, x_base, p_base, n_act;
  logic          ofifo_valid;
  logic [46:0]   inst;
  logic          busy, done;

  core_ctrl #(.row(8), .col(8), .addr_bw(AW)) dut (
    .clk(clk), .reset(reset), .start(start),
    .w_base(w_base), .x_base(x_base), .p_base(p_base), .n_act(n_act),
    .ofifo_valid(ofifo_valid), .inst(inst), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [46:0] inst;
    logic        busy;
    logic        done;
  } exp_t;

  typedef struct {
    logic [AW-1:0] w, x, p, n;
    logic [7:0]    pat;
    int            plen;
    bit            perturb;
    int            rst_at;
    int            exp_done;
    logic [AW-1:0] exp_ap;
    int            exp_nwr;
  } vec_t;

  int          checks = 0;
  int          failures = 0;
  exp_t        q[$];
  int          vpat[$];
  int          done_cyc;
  logic [AW-1:0] last_ap;
  int          nwr;
  vec_t        tbl[7];

  function automatic logic [46:0] idle_w();
    logic [46:0] v;
    v = '0;
    v[46] = 1'b1; v[45] = 1'b1;
    v[32] = 1'b1; v[31] = 1'b1;
    v[19] = 1'b1; v[18] = 1'b1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic push_done();
    exp_t e;
    e.inst = idle_w(); e.busy = 1'b0; e.done = 1'b1;
    q.push_back(e);
    e.done = 1'b0;
    q.push_back(e);
  endtask

  task automatic run_pass(input logic [AW-1:0] w, x, p, n, input bit perturb, input int rst_at);
    exp_t e, ent;
    int   vi, writes, c, v;
    bit   fin;
    @(negedge clk);
    start = 1'b1; w_base = w; x_base = x; p_base = p; n_act = n; ofifo_valid = 1'b0;
    @(posedge clk);
    q.delete();
    writes = 0; vi = 0; fin = 0; done_cyc = -1; last_ap = '0; nwr = 0;
    e.inst = idle_w(); e.busy = 1'b1; e.done = 1'b0;
    q.push_back(e);
    for (int k = 0; k <= 8; k++) begin
      e.inst = idle_w();
      if (k < 8) begin e.inst[19] = 1'b0; e.inst[17:7] = w + AW'(k); end
      if (k >= 1) e.inst[5] = 1'b1;
      q.push_back(e);
    end
    for (int k = 0; k < 16; k++) begin
      e.inst = idle_w(); e.inst[3] = 1'b1; e.inst[0] = 1'b1;
      q.push_back(e);
    end
    if (n == '0) begin
      push_done();
      fin = 1;
    end else begin
      for (int k = 0; k <= int'(n); k++) begin
        e.inst = idle_w();
        if (k < int'(n)) begin e.inst[46] = 1'b0; e.inst[44:34] = x + AW'(k); end
        if (k >= 1) begin e.inst[2] = 1'b1; e.inst[3] = 1'b1; e.inst[1] = 1'b1; end
        q.push_back(e);
      end
    end
    c = 0;
    while (q.size() > 0 && c < 3000) begin
      @(negedge clk);
      ent = q.pop_front();
      chk($sformatf("cyc%0d", c), 64'({inst, busy, done}), 64'(ent));
      if (done) done_cyc = c;
      if (!inst[31]) begin last_ap = inst[30:20]; nwr++; end
      if (reset) reset = 1'b0;
      if (c == rst_at) begin
        reset = 1'b1;
        q.delete();
        fin = 1;
        e.inst = idle_w(); e.busy = 1'b0; e.done = 1'b0;
        q.push_back(e);
        q.push_back(e);
      end
      if (!fin && q.size() == 0) begin
        v = (vi < vpat.size()) ? vpat[vi] : 1;
        vi++;
        ofifo_valid = v[0];
        e.inst = idle_w(); e.busy = 1'b1; e.done = 1'b0;
        if (v != 0) begin
          e.inst[6] = 1'b1; e.inst[32] = 1'b0; e.inst[31] = 1'b0;
          e.inst[30:20] = p + AW'(writes);
          writes++;
        end
        q.push_back(e);
        if (writes == int'(n)) begin push_done(); fin = 1; end
      end else begin
        ofifo_valid = perturb ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      if (perturb && !fin) begin
        start  = 1'($urandom_range(0, 1));
        w_base = AW'($urandom); x_base = AW'($urandom);
        p_base = AW'($urandom); n_act  = AW'($urandom);
      end else begin
        start = 1'b0;
      end
      c++;
    end
    if (c >= 3000) begin
      failures++;
      $display("FAIL timeout pass actual=%0d cycles required=completion", c);
    end
    ofifo_valid = 1'b0;
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; ofifo_valid = 1'b0;
    w_base = '0; x_base = '0; p_base = '0; n_act = '0;
    //            w     x     p     n    pat    len pert rst  done ap   nwr
    tbl[0] = '{11'd0,    11'd16,   11'd100,  11'd4, 8'h2D, 6, 0, -1, 37, 11'd103, 4};
    tbl[1] = '{11'd2044, 11'd2046, 11'd2047, 11'd2, 8'h00, 0, 0, -1, 31, 11'd0,   2};
    tbl[2] = '{11'd3,    11'd5,    11'd7,    11'd0, 8'h00, 0, 0, -1, 26, 11'd0,   0};
    tbl[3] = '{11'd0,    11'd16,   11'd100,  11'd4, 8'h00, 0, 0, 28, -1, 11'd0,   0};
    tbl[4] = '{11'd0,    11'd16,   11'd100,  11'd4, 8'h2D, 6, 0, -1, 37, 11'd103, 4};
    tbl[5] = '{11'd5,    11'd7,    11'd9,    11'd3, 8'h00, 0, 1, -1, 33, 11'd11,  3};
    tbl[6] = '{11'd100,  11'd200,  11'd300,  11'd5, 8'h7C, 7, 0, -1, 39, 11'd304, 5};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_state", 64'({inst, busy, done}), 64'({idle_w(), 1'b0, 1'b0}));
    reset = 1'b0;
    @(negedge clk);
    chk("idle_hold", 64'({inst, busy, done}), 64'({idle_w(), 1'b0, 1'b0}));

    for (int i = 0; i < 7; i++) begin
      vpat.delete();
      for (int b = 0; b < tbl[i].plen; b++) vpat.push_back(int'(tbl[i].pat[b]));
      run_pass(tbl[i].w, tbl[i].x, tbl[i].p, tbl[i].n, tbl[i].perturb, tbl[i].rst_at);
      chk($sformatf("v%0d_done_cycle", i), 64'(done_cyc), 64'(tbl[i].exp_done));
      chk($sformatf("v%0d_last_ap", i), 64'(last_ap), 64'(tbl[i].exp_ap));
      chk($sformatf("v%0d_psum_writes", i), 64'(nwr), 64'(tbl[i].exp_nwr));
      repeat (2) @(negedge clk);
      chk($sformatf("v%0d_quiet", i), 64'({inst, busy, done}), 64'({idle_w(), 1'b0, 1'b0}));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
